// File: rtl/qdec_cabac_package.sv
// Register-bus payload types shared by the QCODEC CABAC blocks.
package qdec_cabac_package;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
  } t_reg_req_s;

  typedef struct packed {
    logic [31:0] rdata;
    logic        rvld;
  } t_reg_resp_s;

endpackage

// File: rtl/qdec_cabac_core_if.sv
// Slice-byte valid/ready stream feeding the CABAC engine.
interface qdec_cabac_core_if;
  logic [7:0] bitstreamFetch;
  logic       bitstreamFetch_vld;
  logic       bitstreamFetch_rdy;

  modport master (output bitstreamFetch, output bitstreamFetch_vld, input bitstreamFetch_rdy);
  modport slave  (input bitstreamFetch, input bitstreamFetch_vld, output bitstreamFetch_rdy);
endinterface

// File: rtl/qdec_cabac_core.sv
// Bypass-bin CABAC decoding engine: byte stream in, packed bins into a line buffer,
// register-bus control/status and level/pulse interrupts.
module qdec_cabac_core
  import qdec_cabac_package::*;
#(
  parameter int unsigned LB_AW = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  t_reg_req_s         reg_req,
  output t_reg_resp_s        reg_resp,
  qdec_cabac_core_if.slave   bs,
  output logic               error_intr,
  output logic               done_intr,
  output logic               ctu_done_intr,
  input  logic [LB_AW-1:0]   lb_raddr,
  output logic [7:0]         lb_dout,
  input  logic               lb_re
);

  localparam int unsigned LB_DEPTH = 2 ** LB_AW;
  localparam int unsigned LB_BINS  = 8 * LB_DEPTH;
  localparam logic [9:0]  RANGE    = 10'd510;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_INIT  = 3'd2;
  localparam logic [2:0] S_DEC   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;

  logic [2:0]  state, state_n;
  logic [15:0] num_bins, num_bins_n, ctu_bins, ctu_bins_n;
  logic [15:0] bin_count, bin_count_n, ctu_cnt, ctu_cnt_n;
  logic        busy, busy_n, done_n, error_n, ctu_pulse_n, rdy_n;
  logic [15:0] sbuf, sbuf_n;
  logic [4:0]  cnt, cnt_n, used, rest;
  logic [8:0]  offset, offset_n;
  logic [7:0]  acc, acc_n, wbyte;
  logic [9:0]  t;
  logic        bin, take, start, clear_buf, last;
  t_reg_resp_s resp_n;

  logic              lb_we;
  logic [LB_AW-1:0]  lb_waddr;
  logic [7:0]        lb_wdata;
  logic [7:0]        lb_mem [LB_DEPTH];

  logic unused_wdata;
  assign unused_wdata = ^reg_req.wdata[31:16];

  // Register bus, FSM, arithmetic decoder and bit buffer next-state logic
  always_comb begin
    state_n     = state;
    num_bins_n  = num_bins;
    ctu_bins_n  = ctu_bins;
    bin_count_n = bin_count;
    ctu_cnt_n   = ctu_cnt;
    busy_n      = busy;
    done_n      = done_intr;
    error_n     = error_intr;
    ctu_pulse_n = 1'b0;
    offset_n    = offset;
    acc_n       = acc;
    resp_n      = '0;
    lb_we       = 1'b0;
    lb_waddr    = '0;
    lb_wdata    = '0;
    used        = '0;
    clear_buf   = 1'b0;
    t           = '0;
    bin         = 1'b0;
    wbyte       = '0;
    last        = 1'b0;
    take        = bs.bitstreamFetch_vld & bs.bitstreamFetch_rdy;
    start       = reg_req.we && (reg_req.addr == 8'h00) && reg_req.wdata[0];

    if (reg_req.we) begin
      case (reg_req.addr)
        8'h04: num_bins_n = reg_req.wdata[15:0];
        8'h08: ctu_bins_n = reg_req.wdata[15:0];
        8'h0C: begin
          if (reg_req.wdata[2]) error_n = 1'b0;
          if (reg_req.wdata[1]) done_n  = 1'b0;
        end
        default: ;
      endcase
    end

    if (reg_req.re) begin
      resp_n.rvld = 1'b1;
      case (reg_req.addr)
        8'h04:   resp_n.rdata = 32'(num_bins);
        8'h08:   resp_n.rdata = 32'(ctu_bins);
        8'h0C:   resp_n.rdata = {29'd0, error_intr, done_intr, busy};
        8'h10:   resp_n.rdata = 32'(bin_count);
        default: resp_n.rdata = '0;
      endcase
    end

    case (state)
      S_IDLE: begin
        if (start) begin
          state_n     = S_CHECK;
          busy_n      = 1'b1;
          bin_count_n = '0;
          ctu_cnt_n   = '0;
          acc_n       = '0;
          clear_buf   = 1'b1;
        end
      end
      S_CHECK: begin
        if (32'(num_bins) > LB_BINS) begin
          state_n = S_ERR;
          error_n = 1'b1;
          busy_n  = 1'b0;
        end else if (num_bins == 16'd0) begin
          state_n = S_DONE;
          done_n  = 1'b1;
          busy_n  = 1'b0;
        end else begin
          state_n = S_INIT;
        end
      end
      S_INIT: begin
        if (cnt >= 5'd9) begin
          used     = 5'd9;
          offset_n = sbuf[15:7];
          if (sbuf[15:7] >= 9'd510) begin
            state_n = S_ERR;
            error_n = 1'b1;
            busy_n  = 1'b0;
          end else begin
            state_n = S_DEC;
          end
        end
      end
      S_DEC: begin
        if (cnt != 5'd0) begin
          used        = 5'd1;
          t           = {offset, sbuf[15]};
          bin         = (t >= RANGE);
          offset_n    = bin ? 9'(t - RANGE) : t[8:0];
          wbyte       = acc | (bin ? (8'h80 >> bin_count[2:0]) : 8'h00);
          bin_count_n = bin_count + 16'd1;
          last        = (bin_count_n == num_bins);
          // A byte is flushed when its eighth bin lands or the run ends mid-byte
          if ((bin_count[2:0] == 3'd7) || last) begin
            lb_we    = 1'b1;
            lb_waddr = LB_AW'(bin_count >> 3);
            lb_wdata = wbyte;
            acc_n    = '0;
          end else begin
            acc_n = wbyte;
          end
          if (ctu_bins != 16'd0) begin
            if (ctu_cnt == ctu_bins - 16'd1) begin
              ctu_pulse_n = 1'b1;
              ctu_cnt_n   = '0;
            end else begin
              ctu_cnt_n = ctu_cnt + 16'd1;
            end
          end
          if (last) begin
            state_n = S_DONE;
            done_n  = 1'b1;
            busy_n  = 1'b0;
          end
        end
      end
      S_DONE, S_ERR: state_n = S_IDLE;
      default:       state_n = S_IDLE;
    endcase

    // Bits are kept MSB-aligned; a new byte lands right below the remaining bits
    rest   = cnt - used;
    sbuf_n = sbuf << used;
    cnt_n  = rest;
    if (take) begin
      sbuf_n = sbuf_n | ({bs.bitstreamFetch, 8'h00} >> rest);
      cnt_n  = rest + 5'd8;
    end
    if (clear_buf) begin
      sbuf_n = '0;
      cnt_n  = '0;
    end
    rdy_n = (cnt_n <= 5'd8) && ((state_n == S_INIT) || (state_n == S_DEC));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                 <= S_IDLE;
      num_bins              <= '0;
      ctu_bins              <= '0;
      bin_count             <= '0;
      ctu_cnt               <= '0;
      busy                  <= 1'b0;
      done_intr             <= 1'b0;
      error_intr            <= 1'b0;
      ctu_done_intr         <= 1'b0;
      offset                <= '0;
      acc                   <= '0;
      sbuf                  <= '0;
      cnt                   <= '0;
      bs.bitstreamFetch_rdy <= 1'b0;
      reg_resp              <= '0;
    end else begin
      state                 <= state_n;
      num_bins              <= num_bins_n;
      ctu_bins              <= ctu_bins_n;
      bin_count             <= bin_count_n;
      ctu_cnt               <= ctu_cnt_n;
      busy                  <= busy_n;
      done_intr             <= done_n;
      error_intr            <= error_n;
      ctu_done_intr         <= ctu_pulse_n;
      offset                <= offset_n;
      acc                   <= acc_n;
      sbuf                  <= sbuf_n;
      cnt                   <= cnt_n;
      bs.bitstreamFetch_rdy <= rdy_n;
      reg_resp              <= resp_n;
    end
  end

  // Line buffer storage has no reset; contents are only meaningful after a decode
  always_ff @(posedge clk) begin
    if (lb_we) lb_mem[lb_waddr] <= lb_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     lb_dout <= '0;
    else if (lb_re) lb_dout <= lb_mem[lb_raddr];
  end

endmodule

// File: tb/tb_qdec_cabac_core.sv
// Self-checking bench for qdec_cabac_core: directed and random decodes against a bin-level model.
module tb_qdec_cabac_core;
  import qdec_cabac_package::*;

  logic        clk = 1'b0;
  logic        rst_n;
  t_reg_req_s  req;
  t_reg_resp_s resp;
  logic        err_i, done_i, ctu_i;
  logic [11:0] lb_raddr;
  logic [7:0]  lb_dout;
  logic        lb_re;

  qdec_cabac_core_if bs_if ();

  qdec_cabac_core #(.LB_AW(12)) dut (
    .clk(clk), .rst_n(rst_n), .reg_req(req), .reg_resp(resp), .bs(bs_if),
    .error_intr(err_i), .done_intr(done_i), .ctu_done_intr(ctu_i),
    .lb_raddr(lb_raddr), .lb_dout(lb_dout), .lb_re(lb_re)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int failed = 0;

  logic [7:0] stim [$];
  logic [7:0] shadow [4096];
  bit         known  [4096];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reg_write(input logic [7:0] addr, input logic [31:0] data);
    req.we = 1'b1; req.addr = addr; req.wdata = data;
    @(negedge clk);
    req.we = 1'b0; req.wdata = '0;
  endtask

  task automatic reg_read(input string tag, input logic [7:0] addr, output logic [31:0] data);
    req.re = 1'b1; req.addr = addr;
    @(negedge clk);
    req.re = 1'b0;
    chk({tag, "/rvld"}, 32'(resp.rvld), 32'd1);
    data = resp.rdata;
  endtask

  task automatic lb_read(input int addr, output logic [7:0] data);
    lb_re = 1'b1; lb_raddr = 12'(addr);
    @(negedge clk);
    lb_re = 1'b0;
    data = lb_dout;
  endtask

  function automatic int getbit(input int i);
    logic [7:0] v;
    v = stim[i / 8];
    return int'(v[7 - (i % 8)]);
  endfunction

  // One complete decode: program, start, feed bytes, then check flags, counters and line buffer
  task automatic run(input string name, input int nb, input int ctu, input bit slow);
    bit         exp_err;
    int         off, tt, b, idx, pulses, took;
    bit         fin, rdy_seen;
    logic [7:0] eb [4096];
    logic [31:0] rd;
    logic [7:0] lbv;
    int         budget;

    exp_err = 1'b0;
    for (int j = 0; j < (nb + 7) / 8 && j < 4096; j++) eb[j] = 8'h00;
    if (nb > 32768) exp_err = 1'b1;
    else if (nb != 0) begin
      off = 0;
      for (int i = 0; i < 9; i++) off = off * 2 + getbit(i);
      if (off >= 510) exp_err = 1'b1;
      else begin
        for (int k = 0; k < nb; k++) begin
          tt = off * 2 + getbit(9 + k);
          if (tt >= 510) begin b = 1; off = tt - 510; end
          else begin b = 0; off = tt; end
          if (b == 1) eb[k / 8] = eb[k / 8] | (8'h80 >> (k % 8));
        end
      end
    end

    reg_write(8'h0C, 32'h6);
    chk({name, "/w1c"}, 32'({err_i, done_i}), 32'd0);
    reg_write(8'h04, 32'(nb[15:0]));
    reg_write(8'h08, 32'(ctu));
    reg_write(8'h00, 32'h1);

    idx = 0; pulses = 0; took = 0; fin = 1'b0; rdy_seen = 1'b0;
    budget = 200 + 4 * (nb > 32768 ? 16 : nb + 16);
    for (int cyc = 0; cyc < budget && !fin; cyc++) begin
      if (ctu_i) pulses++;
      if (done_i || err_i) begin
        fin = 1'b1;
        took = cyc + 1;
      end else begin
        bs_if.bitstreamFetch_vld = (idx < stim.size()) && (!slow || (cyc % 4 == 0));
        bs_if.bitstreamFetch     = (idx < stim.size()) ? stim[idx] : 8'h00;
        if (bs_if.bitstreamFetch_rdy) rdy_seen = 1'b1;
        if (bs_if.bitstreamFetch_vld && bs_if.bitstreamFetch_rdy) idx++;
        @(negedge clk);
      end
    end
    bs_if.bitstreamFetch_vld = 1'b0;

    chk({name, "/finished"}, 32'(fin), 32'd1);
    chk({name, "/error"}, 32'(err_i), 32'(exp_err));
    chk({name, "/done"}, 32'(done_i), 32'(!exp_err));
    chk({name, "/ctu_pulses"}, 32'(pulses), (exp_err || ctu == 0) ? 32'd0 : 32'(nb / ctu));
    reg_read({name, "/bc"}, 8'h10, rd);
    chk({name, "/bin_count"}, rd, exp_err ? 32'd0 : 32'(nb));
    if (nb == 0 || nb > 32768) begin
      chk({name, "/no_bytes"}, 32'(idx), 32'd0);
      chk({name, "/rdy_low"}, 32'(rdy_seen), 32'd0);
    end
    if (nb == 0) chk({name, "/latency_le3"}, 32'(took <= 3), 32'd1);

    if (!exp_err) begin
      for (int j = 0; j < (nb + 7) / 8; j++) begin
        shadow[j] = eb[j];
        known[j]  = 1'b1;
      end
    end
    for (int j = 0; j < 4 || j < (nb + 7) / 8; j++) begin
      if (j < 4096 && known[j]) begin
        lb_read(j, lbv);
        chk($sformatf("%s/lb[%0d]", name, j), 32'(lbv), 32'(shadow[j]));
      end
    end
  endtask

  logic [31:0] rd0;
  int          nbr, ctr;

  initial begin
    rst_n = 1'b0;
    req = '0;
    lb_re = 1'b0; lb_raddr = '0;
    bs_if.bitstreamFetch = '0; bs_if.bitstreamFetch_vld = 1'b0;
    for (int j = 0; j < 4096; j++) known[j] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("rst_flags", 32'({err_i, done_i, ctu_i, bs_if.bitstreamFetch_rdy, resp.rvld}), 32'd0);
    chk("rst_rdata", resp.rdata, 32'd0);
    chk("rst_lb_dout", 32'(lb_dout), 32'd0);
    reg_read("rst_status", 8'h0C, rd0);
    chk("rst_status", rd0, 32'd0);
    reg_read("rst_unmapped", 8'h14, rd0);
    chk("rst_unmapped", rd0, 32'd0);

    stim = '{8'h80, 8'h00, 8'h00};
    run("dir8", 8, 0, 1'b0);
    reg_read("numbins_rb", 8'h04, rd0);
    chk("numbins_rb", rd0, 32'd8);

    stim = '{8'hFF, 8'hFF};
    run("off511", 8, 0, 1'b0);
    reg_write(8'h0C, 32'h4);
    chk("w1c_error", 32'(err_i), 32'd0);

    stim = {};
    run("nb0", 0, 0, 1'b0);

    stim = '{8'h00, 8'h00, 8'h00, 8'h00};
    run("ctu4", 16, 4, 1'b0);

    for (int r = 0; r < 4; r++) begin
      nbr = int'($urandom_range(1, 120));
      ctr = int'($urandom_range(0, 9));
      stim = {};
      for (int j = 0; j < (9 + nbr + 7) / 8 + 1; j++) stim.push_back(8'($urandom));
      run($sformatf("rnd%0d_full", r), nbr, ctr, 1'b0);
      run($sformatf("rnd%0d_slow", r), nbr, ctr, 1'b1);
    end

    stim = {};
    run("big", 32769, 0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
